// File: rtl/fft_twiddle_sequencer.sv
// ============================================================================
// Module   : fft_twiddle_sequencer
// Purpose  : Walks all 5 stages x 16 butterflies of a 32-point radix-2 DIF FFT.
//            Each butterfly gets its sample addresses and its W32^k twiddle,
//            with both twiddle words in sign-magnitude form.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_twiddle_sequencer #(
  parameter int WEIGHT_BITS = 12,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [2:0]             stage,
  output logic [3:0]             bfly_idx,
  output logic [ADDR_BITS-1:0]   addr_top,
  output logic [ADDR_BITS-1:0]   addr_bot,
  output logic [WEIGHT_BITS-1:0] tw_re,
  output logic [WEIGHT_BITS-1:0] tw_im,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_last_stage = 3'd4;
  localparam logic [3:0] c_last_bfly  = 4'd15;

  state_t r_state;
  state_t w_state_next;

  logic                   w_load;
  logic                   w_clear;
  logic                   w_xfer;
  logic                   w_last;
  logic [2:0]             w_ld_stage;
  logic [3:0]             w_ld_j;

  logic [2:0]             r_stage;
  logic [3:0]             r_j;
  logic [ADDR_BITS-1:0]   r_top;
  logic [ADDR_BITS-1:0]   r_bot;
  logic [WEIGHT_BITS-1:0] r_tw_re;
  logic [WEIGHT_BITS-1:0] r_tw_im;

  logic [4:0]             w_span;
  logic [3:0]             w_mask;
  logic [3:0]             w_p;
  logic [3:0]             w_k;
  logic [4:0]             w_top;
  logic [4:0]             w_bot;
  logic [10:0]            w_re_mag;
  logic [10:0]            w_im_mag;
  logic                   w_re_sign;
  logic                   w_im_sign;

  // Quarter-wave magnitude of cos(2*pi*i/32), i = 0..8.
  function automatic logic [10:0] mag(input logic [3:0] i);
    case (i)
      4'd0:    mag = 11'b11111111111;
      4'd1:    mag = 11'b11111011000;
      4'd2:    mag = 11'b11101100100;
      4'd3:    mag = 11'b11010100111;
      4'd4:    mag = 11'b10110101000;
      4'd5:    mag = 11'b10001110010;
      4'd6:    mag = 11'b01100010000;
      4'd7:    mag = 11'b00110001111;
      default: mag = 11'b00000000000;
    endcase
  endfunction

  assign w_xfer = (r_state == ST_RUN) && out_ready;
  assign w_last = (r_stage == c_last_stage) && (r_j == c_last_bfly);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_ld_stage   = r_stage;
    w_ld_j       = r_j;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
          w_ld_stage   = 3'd0;
          w_ld_j       = 4'd0;
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_next = ST_DONE;
            w_clear      = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_ld_j     = r_j + 4'd1;
            w_ld_stage = (r_j == c_last_bfly) ? r_stage + 3'd1 : r_stage;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Top address is j with a zero bit inserted at the span position.
  always_comb begin
    w_span = 5'd16 >> w_ld_stage;
    w_mask = w_span[3:0] - 4'd1;
    w_p    = w_ld_j & w_mask;
    w_top  = {w_ld_j & ~w_mask, 1'b0} | {1'b0, w_p};
    w_bot  = w_top + w_span;
    w_k    = w_p << w_ld_stage;
  end

  // Second quadrant mirrors the first: 16-k wraps to -k in four bits.
  always_comb begin
    w_re_mag  = (w_k <= 4'd8) ? mag(w_k) : mag(4'd0 - w_k);
    w_im_mag  = (w_k <= 4'd8) ? mag(4'd8 - w_k) : mag(w_k - 4'd8);
    w_re_sign = (w_k > 4'd8) && (|w_re_mag);
    w_im_sign = (w_k != 4'd0) && (|w_im_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_j     <= '0;
      r_top   <= '0;
      r_bot   <= '0;
      r_tw_re <= '0;
      r_tw_im <= '0;
    end else if (w_clear) begin
      r_stage <= '0;
      r_j     <= '0;
      r_top   <= '0;
      r_bot   <= '0;
      r_tw_re <= '0;
      r_tw_im <= '0;
    end else if (w_load) begin
      r_stage <= w_ld_stage;
      r_j     <= w_ld_j;
      r_top   <= w_top;
      r_bot   <= w_bot;
      r_tw_re <= {w_re_sign, w_re_mag};
      r_tw_im <= {w_im_sign, w_im_mag};
    end
  end

  assign out_valid = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign stage     = r_stage;
  assign bfly_idx  = r_j;
  assign addr_top  = r_top;
  assign addr_bot  = r_bot;
  assign tw_re     = r_tw_re;
  assign tw_im     = r_tw_im;

endmodule

`default_nettype wire

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
Address and twiddle generator for the 32-point radix-2 decimation-in-frequency FFT datapath.
- Per butterfly, it emits the top/bottom sample addresses and the twiddle weight W32^k as two 12-bit sign-magnitude words (real = cos, imag = -sin).
- The weight encoding is exactly the one the twiddle multiplier decodes.
- It sits directly upstream of the multiplier and butterfly, walking all 5 stages x 16 butterflies under a valid/ready handshake.

Parameters:
- weight_bits, 12, twiddle width: 1 sign bit + 11 fraction bits. Fixed by the code table; other values are unsupported.
- addr_bits, 5, sample address width (N = 32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to sequence a full transform. Honoured only in IDLE.
- out_ready  in  1  downstream accepts the current butterfly.
- out_valid  out  1  butterfly descriptor valid.
- stage  out  3  stage number 0..4.
- bfly_idx  out  4  butterfly index j, 0..15, within the stage.
- addr_top  out  addr_bits  upper-leg sample address.
- addr_bot  out  addr_bits  lower-leg sample address.
- tw_re  out  weight_bits  sign-magnitude cos(2πk/32).
- tw_im  out  weight_bits  sign-magnitude -sin(2πk/32).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
Reset:
- Asynchronous on rst_n low. State goes to IDLE.
- All outputs go to 0 immediately, including out_valid, busy and done.
- Reset asserted mid-transform aborts it; no done pulse is produced.

FSM:
- IDLE -> RUN on start=1. The stage and j counters clear, and the registered outputs present (s=0, j=0) with out_valid=1 on the next edge. Latency start -> first out_valid is 1 cycle.
- RUN: a transfer occurs when out_valid & out_ready, and the descriptor advances on that edge.
  - j=15 wraps to 0 and the stage increments.
  - The transfer at s=4, j=15 moves the FSM to DONE.
- Without a transfer, all outputs hold bit-stable.
- DONE lasts exactly one cycle: done=1, out_valid=0, busy=1. It then returns to IDLE with busy=0.
- start outside IDLE is ignored, including in the DONE cycle.
- Total transfers per transform: 80.

Address and exponent, for stage s and butterfly j:
- span = 16 >> s
- g = j >> (4-s)
- p = j & (span-1)
- addr_top = 2*g*span + p
- addr_bot = addr_top + span
- k = p << s, giving k in 0..15

Magnitude table m(i), 11 bits, i = 0..8:
- i=0: 11111111111 (represents 1.0)
- i=1: 11111011000
- i=2: 11101100100
- i=3: 11010100111
- i=4: 10110101000
- i=5: 10001110010
- i=6: 01100010000
- i=7: 00110001111
- i=8: 00000000000

Twiddle words:
- tw_re = {k>8, (k<=8 ? m(k) : m(16-k))}
- tw_im = {k!=0, (k<=8 ? m(8-k) : m(k-8))}

Zero rules:
- A zero magnitude is always emitted with sign 0 (+0, never -0).
- At k=8, tw_re is 0x000.
- At k=0, tw_im is 0x000.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-clock -> all outputs 0 asynchronously. Release with no start -> out_valid stays 0, busy=0.
2. start, out_ready=1 -> one cycle later: stage=0, j=0, top=0, bot=16, tw_re=0x7FF, tw_im=0x000.
   - At s=0, j=5: top=5, bot=21, tw_re=0x472, tw_im=0xEA7.
3. Mid-transform descriptors:
   - s=1, j=9: top=17, bot=25, tw_re=0x764, tw_im=0xB10.
   - s=2, j=3: top=3, bot=7, tw_re=0xDA8, tw_im=0xDA8.
   - s=4, j=3: top=6, bot=7, tw_re=0x7FF, tw_im=0x000.
4. Backpressure: drop out_ready for 7 cycles at s=0, j=8 -> descriptor holds bit-stable (top=8, bot=24, tw_re=0x000, tw_im=0xFFF). Resume -> next is j=9 with no skip or duplicate.
5. Completion: exactly 80 accepted transfers, then done=1 for one cycle with out_valid=0. Next cycle busy=0. start pulsed during RUN and during DONE -> ignored; a new start in IDLE restarts at s=0, j=0.
6. Abort: rst_n low at s=2, j=7 -> immediate IDLE with all outputs 0 and no done. A subsequent start yields a full 80-transfer sequence.
